// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (tx state encoding, bit-period helpers).
// Used by the transmitter today and intended for the receive block as well.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Clock cycles per bit period; integer divide, no fractional correction.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Width of a counter that must hold values 0..clks-1.
    function automatic int unsigned baud_cnt_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: loadable down-counter producing one bit_tick per bit period.
// restart reloads the counter so a new bit period begins on the next cycle.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS  = 434,
    parameter int unsigned WIDTH = baud_cnt_width(CLKS)
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam logic [WIDTH-1:0] RELOAD = WIDTH'(CLKS - 1);

    logic [WIDTH-1:0] cnt;

    // Count down from CLKS-1; reload on terminal count or on restart.
    always_ff @(posedge clk) begin
        if (rst || restart || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign bit_tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-level 8N1/8N2 UART transmitter with overrun flag
// and frame counter. Define UART_TX_PARITY_EN to insert a parity bit
// (even or odd per PARITY_ODD) between the data bits and the stop bit(s).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  UARTSend,
    input  logic        UARTDatLock,
    output logic        UARTAvl,
    output logic        TxD,
    output logic        TxBusy,
    output logic        Overrun,
    input  logic        OvrClr,
    output logic [15:0] ByteCnt
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [2:0]  LAST_STOP    = 3'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_tx_serializer: CLK_HZ/BAUD must be at least 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end

    tx_state_t   state, state_n;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        txd_n, avl_n, busy_n, cnt_inc;
    logic        lock_d, lock_rise, bit_tick;

    assign lock_rise = UARTDatLock & ~lock_d;

    uart_baud_tick #(
        .CLKS  (CLKS_PER_BIT),
        .WIDTH (baud_cnt_width(CLKS_PER_BIT))
    ) u_baud (
        .clk      (Clk),
        .rst      (Rst),
        .restart  (state == IDLE),
        .bit_tick (bit_tick)
    );

`ifdef UART_TX_PARITY_EN
    logic par_q;

    // Latch the parity of the offered byte at capture; shreg is consumed by shifting.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            par_q <= 1'b0;
        end else if (state == IDLE && lock_rise) begin
            par_q <= (^UARTSend) ^ PARITY_ODD[0];
        end
    end
`endif

    // Edge-detect register; follows the level through reset so a held-high lock is not an edge.
    always_ff @(posedge Clk) begin
        lock_d <= UARTDatLock;
    end

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            TxD     <= 1'b1;
            UARTAvl <= 1'b0;
            TxBusy  <= 1'b0;
            ByteCnt <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_idx <= bit_idx_n;
            TxD     <= txd_n;
            UARTAvl <= avl_n;
            TxBusy  <= busy_n;
            ByteCnt <= ByteCnt + {15'd0, cnt_inc};
        end
    end

    // Next-state, shift and handshake logic; TxD is derived from the state being entered
    // so the registered line changes on the same edge as the state.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        avl_n     = UARTAvl;
        busy_n    = TxBusy;
        cnt_inc   = 1'b0;
        txd_n     = 1'b1;

        case (state)
            IDLE: begin
                avl_n  = 1'b1;
                busy_n = 1'b0;
                if (lock_rise) begin
                    shreg_n = UARTSend;
                    avl_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_n   = {1'b0, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_n   = STOP;
                    bit_idx_n = '0;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (bit_idx == LAST_STOP) begin
                        state_n = IDLE;
                        avl_n   = 1'b1;
                        busy_n  = 1'b0;
                        cnt_inc = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_n = par_q;
`endif
            default: txd_n = 1'b1;
        endcase
    end

    // Sticky overrun flag; a new overrun takes priority over a clear in the same cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Overrun <= 1'b0;
        end else if (lock_rise && state != IDLE) begin
            Overrun <= 1'b1;
        end else if (OvrClr) begin
            Overrun <= 1'b0;
        end
    end

endmodule
